// File: rtl/mult_pkg.sv
// Shared types for the time-multiplexed 32x32 multiplier controller.
// Holds the FSM encoding, default widths and per-state partial-product shifts.
package mult_pkg;

  localparam int N_DEF = 32;
  localparam int H_DEF = N_DEF / 2;
  localparam int P_DEF = 2 * N_DEF;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } state_t;

  // Cross terms land at H, the high-by-high term at 2H.
  function automatic int pp_shift(state_t s, int h);
    case (s)
      PP1, PP2: return h;
      PP3:      return 2 * h;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/mult32_seq_ctrl_mul16.sv
// Combinational half-width unsigned multiplier shared by the sequencing controller.
// Zero latency; no handshake, the caller holds inputs stable for the cycle.
module Multiplier16x16 #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/mult32_seq_ctrl.sv
// Four-cycle NxN unsigned multiply through one shared half-width multiplier.
// Latency 5 cycles from input handshake to out_valid; result held until out_ready.
module mult32_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N-1:0] Product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int H = N / 2;
  localparam int W = 2 * N;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [H-1:0]   mul_a, mul_b;
  logic [N-1:0]   mul_p;
  logic [W-1:0]   pp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PP0;
      PP0:     state_d = PP1;
      PP1:     state_d = PP2;
      PP2:     state_d = PP3;
      PP3:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand halves are gated to zero outside PPk so the multiplier stays quiet.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      PP0: begin mul_a = a_q[H-1:0]; mul_b = b_q[H-1:0]; end
      PP1: begin mul_a = a_q[N-1:H]; mul_b = b_q[H-1:0]; end
      PP2: begin mul_a = a_q[H-1:0]; mul_b = b_q[N-1:H]; end
      PP3: begin mul_a = a_q[N-1:H]; mul_b = b_q[N-1:H]; end
      default: ;
    endcase
  end

  Multiplier16x16 #(
    .W (H)
  ) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign pp_ext = {{N{1'b0}}, mul_p};

  // The full product fits in W bits, so the accumulator needs no carry out.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          acc_d = '0;
        end
      end
      PP0, PP1, PP2, PP3: acc_d = acc_q + (pp_ext << pp_shift(state_q, H));
      default: ;
    endcase
  end

  assign Product = acc_q;

endmodule
